audio_mix_i2s: RTL

- Downstream consumer of the ALSA PCM reader.
- Mixes the core's native 16-bit stereo audio with the ALSA PCM stream, saturates, applies attenuation/mute, and serialises the result as a 48 kHz 16-bit-in-32-slot I2S stream for the HDMI/analog audio codec.
- Generates its own BCLK/LRCLK from the system audio clock and emits a per-frame strobe.

---
 rtl/audio_mix_i2s.sv | 135 +++++++++++++
 1 files changed

// File: rtl/audio_mix_i2s.sv
// audio_mix_i2s: mixes the core's 16-bit stereo audio with the ALSA PCM stream,
// saturates, applies attenuation/mute and serialises the result as a
// 16-bit-in-32-slot I2S stream with locally generated BCLK/LRCLK.
module audio_mix_i2s #(
  parameter int CLK_RATE    = 24576000,
  parameter int SAMPLE_RATE = 48000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] core_l,
  input  logic [15:0] core_r,
  input  logic [15:0] alsa_l,
  input  logic [15:0] alsa_r,
  input  logic        alsa_en,
  input  logic [4:0]  att,
  output logic        i2s_bclk,
  output logic        i2s_lrclk,
  output logic        i2s_data,
  output logic        frame_tick
);

  // clk cycles per BCLK period; 64 BCLKs make one frame
  localparam int DIV = CLK_RATE / (SAMPLE_RATE * 64);
  localparam int DCW = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [DCW-1:0] DCNT_LAST = DCW'(DIV - 1);
  localparam logic [DCW-1:0] DCNT_HALF = DCW'(DIV / 2);

  generate
    if ((DIV < 2) || (DIV % 2 != 0) || (DIV * SAMPLE_RATE * 64 != CLK_RATE)) begin : g_div_check
      $error("audio_mix_i2s: CLK_RATE must be an even multiple (>= 2) of SAMPLE_RATE*64");
    end
  endgenerate

  logic [DCW-1:0] dcnt;
  logic [DCW-1:0] dcnt_next;
  logic           dcnt_wrap;
  logic [5:0]     bidx;
  logic [5:0]     bidx_next;
  logic           frame_start;
  logic           slot_bit;
  logic [15:0]    mix_l;
  logic [15:0]    mix_r;
  logic [15:0]    shl;
  logic [15:0]    shr;
  logic [4:0]     att_q;
  logic [16:0]    sum_l;
  logic [16:0]    sum_r;

  // Clamp a 17-bit signed sum of two 16-bit samples into 16-bit range.
  function automatic logic [15:0] saturate(input logic [16:0] s);
    case (s[16:15])
      2'b01:   return 16'h7FFF;
      2'b10:   return 16'h8000;
      default: return s[15:0];
    endcase
  endfunction

  // Mute, or arithmetic right shift that keeps the sample's sign.
  function automatic logic [15:0] attenuate(input logic [15:0] v, input logic [4:0] a);
    logic signed [15:0] sv;
    sv = v;
    return a[4] ? 16'h0000 : 16'(sv >>> a[3:0]);
  endfunction

  assign dcnt_wrap   = (dcnt == DCNT_LAST);
  assign dcnt_next   = dcnt_wrap ? '0 : dcnt + 1'b1;
  assign bidx_next   = bidx + 6'd1;
  assign frame_start = dcnt_wrap && (bidx == 6'd63);

  assign sum_l = {core_l[15], core_l} + (alsa_en ? {alsa_l[15], alsa_l} : 17'd0);
  assign sum_r = {core_r[15], core_r} + (alsa_en ? {alsa_r[15], alsa_r} : 17'd0);

  // Bit that goes on the wire for the next bit index (one-bit I2S delay).
  // NOTE: every output of an always_comb gets a default first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    slot_bit = 1'b0;
    if ((bidx_next >= 6'd1) && (bidx_next <= 6'd16)) begin
      slot_bit = shl[4'(6'd16 - bidx_next)];
    end else if ((bidx_next >= 6'd33) && (bidx_next <= 6'd48)) begin
      slot_bit = shr[4'(6'd48 - bidx_next)];
    end
  end

  // Clock divider, bit counter and the registered I2S pins; everything that
  // moves on a BCLK falling edge updates on the cycle dcnt wraps.
  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dcnt       <= '0;
      bidx       <= '0;
      i2s_bclk   <= 1'b0;
      i2s_lrclk  <= 1'b0;
      i2s_data   <= 1'b0;
      frame_tick <= 1'b0;
    end else begin
      dcnt       <= dcnt_next;
      i2s_bclk   <= (dcnt_next >= DCNT_HALF);
      frame_tick <= frame_start;
      if (dcnt_wrap) begin
        bidx      <= bidx_next;
        i2s_lrclk <= bidx_next[5];
        i2s_data  <= slot_bit;
      end
    end
  end

  // Mix stage, recomputed every clk. It uses the attenuation latched at the
  // previous frame start, so an att change is seen by the transmitted words
  // one frame after the frame_tick that samples it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mix_l <= '0;
      mix_r <= '0;
    end else begin
      mix_l <= attenuate(saturate(sum_l), att_q);
      mix_r <= attenuate(saturate(sum_r), att_q);
    end
  end

  // Frame-start capture of the outgoing words and the attenuation setting.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shl   <= '0;
      shr   <= '0;
      att_q <= '0;
    end else if (frame_start) begin
      shl   <= mix_l;
      shr   <= mix_r;
      att_q <= att;
    end
  end

endmodule
